vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 77 +++++++
 tb/tb_vga_timing_gen.sv | 107 ++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA hcount/vcount, sync and blanking source with one-cycle frame-start strobe.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        frame_start,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic [11:0] rgb
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS = H_ACTIVE + H_FP;
  localparam int H_SE = H_SS + H_SYNC;
  localparam int V_SS = V_ACTIVE + V_FP;
  localparam int V_SE = V_SS + V_SYNC;
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 2048");
  end
  logic [10:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic        h_wrap, v_wrap;
  assign hcount = h_cnt;
  assign vcount = v_cnt;
  assign rgb    = 12'h000;
  always_comb begin
    h_wrap = h_cnt == 11'(H_TOTAL - 1);
    v_wrap = v_cnt == 11'(V_TOTAL - 1);
    h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_nxt  = h_wrap ? (v_wrap ? 11'd0 : v_cnt + 11'd1) : v_cnt;
  end
  // Decode is taken from the next count so flags land on the same edge as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hblnk       <= h_nxt >= 11'(H_ACTIVE);
      hsync       <= h_nxt >= 11'(H_SS) && h_nxt < 11'(H_SE);
      vblnk       <= v_nxt >= 11'(V_ACTIVE);
      vsync       <= v_nxt >= 11'(V_SS) && v_nxt < 11'(V_SE);
      frame_start <= h_wrap && v_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (en && h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-enable check of vga_timing_gen against an arithmetic position model.
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        frame_start;
  logic [10:0] hcount, vcount;
  logic        hsync, hblnk, vsync, vblnk;
  logic [11:0] rgb;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int pos = 0;
  bit exp_fs = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
    .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
    .vcount(vcount), .vsync(vsync), .vblnk(vblnk), .rgb(rgb)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  // Expected outputs derived from the enabled-cycle count since reset.
  task automatic check_all();
    int h, v;
    h = pos % HT;
    v = (pos / HT) % VT;
    chk("hcount", 16'(hcount), 16'(h));
    chk("vcount", 16'(vcount), 16'(v));
    chk("hblnk", 16'(hblnk), 16'(h >= HA));
    chk("hsync", 16'(hsync), 16'(h >= HA + HF && h < HA + HF + HS));
    chk("vblnk", 16'(vblnk), 16'(v >= VA));
    chk("vsync", 16'(vsync), 16'(v >= VA + VF && v < VA + VF + VS));
    chk("rgb", 16'(rgb), 16'd0);
    chk("frame_start", 16'(frame_start), 16'(exp_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, 16'(pos / FRAME));
`endif
  endtask

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    if (rst_n && e) begin
      pos++;
      exp_fs = (pos % FRAME) == 0;
    end else begin
      exp_fs = 1'b0;
    end
    #1 check_all();
  endtask

  initial begin
    // Reset held for 5 cycles: everything zero
    for (int i = 0; i < 5; i++) step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    chk("first_edge_h", 16'(hcount), 16'd1);
    for (int i = 0; i < HT - 1; i++) step(1'b1);
    chk("line_wrap_v", 16'(vcount), 16'd1);
    // Three-plus frames with random enable gaps
    for (int i = 0; i < 3 * FRAME + 50; i++) step($urandom_range(0, 7) != 0);
    // Freeze mid-line for 10 cycles
    for (int i = 0; i < FRAME && (pos % HT) != HA / 2; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("freeze_hold", 16'(hcount), 16'(HA / 2));
    step(1'b1);
    chk("resume_next", 16'(hcount), 16'(HA / 2 + 1));
    for (int i = 0; i < 5; i++) step(1'b1);
    // Async reset between edges at mid-frame
    for (int i = 0; i < FRAME && ((pos / HT) % VT) != VT / 2; i++) step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1);
    #2 rst_n = 1'b0;
    pos = 0;
    exp_fs = 1'b0;
    #1 check_all();
    step(1'b1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < FRAME + 40; i++) step($urandom_range(0, 5) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
